uart_tb_tx: RTL and testbench
=============================

// Module: uart_tb_tx
// PURPOSE
//  Clocked UART transmitter VIP for uDMA UART benches: drives the DUT's rx pin with 8N1 (optional 8E1) frames.
//  Bytes are queued through a valid/ready port and serialised LSB-first at a runtime-programmable bit period.
//  Sits in udma_vips/uart beside the UART receiver VIP; the two are wired back-to-back for loopback checks.
// PARAMETERS
//  FIFO_DEPTH   8    byte queue entries, power of two, >= 2
//  DIV_W        16   width of bit-period divider
// PORTS
//  clk_i        in   1      single clock, all logic on posedge
//  rst_i        in   1      synchronous, active-high reset
//  tx_en_i      in   1      1: start frames from queue; 0: stay idle after current frame
//  cfg_div_i    in   DIV_W  clocks per bit minus 1 (0 => 1 clk/bit)
//  data_i       in   8      byte to queue
//  valid_i      in   1      push request
//  ready_o      out  1      queue not full; push occurs when valid_i & ready_o
//  tx_o         out  1      serial line, idle high
//  busy_o       out  1      frame in progress or queue non-empty
//  byte_done_o  out  1      1-cycle pulse at end of each stop bit
//  line_done_o  out  1      1-cycle pulse with byte_done_o when sent byte == 8'h0A
// BEHAVIOUR
//  Reset: tx_o=1, ready_o=1 the cycle after reset; busy_o, byte_done_o, line_done_o = 0; queue flushed; FSM=IDLE.
//  Reset mid-frame aborts it: tx_o=1 on the next cycle, no done pulse.
//  FSM: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP -> IDLE, or STOP -> START back-to-back.
//  IDLE: leave when tx_en_i & queue non-empty; pop head into shift reg and latch cfg_div_i.
//  Latched divider is used for the whole frame; cfg_div_i changes mid-frame take effect next frame.
//  Each bit holds tx_o for (div+1) clocks; the bit counter is 3 bits and the divider counter DIV_W bits.
//  START drives 0; DATA drives shift[0], shifts right each bit; STOP drives 1 for one bit period.
//  tx_o is registered: first START clock is the cycle after the pop.
//  STOP end: pulse byte_done_o (and line_done_o if byte==0x0A).
//  If tx_en_i & queue non-empty, enter START on the next cycle (no extra idle bit); else IDLE.
//  tx_en_i low mid-frame: current frame completes; no new frame starts.
//  Queue: ready_o = !full (registered). A push while full is ignored.
//  Simultaneous push+pop: allowed when not full; level unchanged.
//  A push into an empty queue is poppable the following cycle.
//  Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
// CONFIGURATION
//  `UART_TB_TX_PARITY_EN defined: PARITY state between DATA and STOP drives even parity (^byte); frame = 11 bits.
//  This matches a receiver that flags an error when the XOR of parity and data is 1.
//  Undefined: PARITY state and logic absent; frame = 10 bits.
// STRUCTURE
//  uart_tb_pkg: typedef enum logic [2:0] {IDLE,START,DATA,PARITY,STOP} uart_tx_state_e; localparam LF = 8'h0A.
//  Sub-module uart_tb_tx_fifo (FIFO_DEPTH x 8, push/pop/full/empty, sync active-high reset).
//  Top holds FSM, divider counter, bit counter and shift reg.
// TESTING
//  div=3, push 0x55, tx_en=1 -> tx_o = 0,1,0,1,0,1,0,1,0,1 each 4 clks; byte_done_o pulses at clk 40 of frame.
//  div=0, push 0x0A -> 10-clk frame; line_done_o and byte_done_o pulse together.
//  Push 9 bytes back-to-back with tx_en=0, depth 8 -> ready_o low after 8th; 9th dropped.
//    Then tx_en=1 -> 8 frames, zero idle bits between them.
//  Parity build, div=1, push 0x07 -> parity bit 1.
//    Push 0x03 -> parity bit 0; frames 22 clks; loopback receiver reports no parity error.
//  Assert rst_i during DATA bit 4 -> tx_o=1 next clk, busy_o=0, ready_o=1, no done pulse, queue empty.
//  Change div 3->1 during frame -> current frame 4 clks/bit, next frame 2 clks/bit.

Source files
------------

// File: rtl/uart_tb_pkg.sv
// Shared types and constants for the UART transmitter VIP.
// Contents: transmitter FSM state type, byte type, line-feed code, parity helper.
package uart_tb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    typedef logic [7:0] uart_byte_t;

    localparam uart_byte_t LF = 8'h0A;

    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity(input uart_byte_t b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tb_tx_if.sv
// Byte push port of the UART transmitter VIP (valid/ready handshake).
// Signals: data  - byte to queue
//          valid - push request from the producer
//          ready - queue not full; a push happens when valid & ready
// Modports: master (producer side), slave (transmitter side).
interface uart_tb_tx_if;
    import uart_tb_pkg::*;

    uart_byte_t data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_tb_tx_fifo.sv
// Byte queue for the UART transmitter VIP.
// Ports: clk_i, rst_i     - clock, synchronous active-high reset (flushes queue)
//        push, push_data  - write request and byte; ignored while full
//        pop              - read request; ignored while empty
//        head             - byte at the head of the queue
//        ready            - registered !full
//        empty            - registered empty flag
//        empty_nxt_c      - empty flag as it will be after this clock
module uart_tb_tx_fifo
    import uart_tb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push,
    input  uart_byte_t push_data,
    input  logic       pop,
    output uart_byte_t head,
    output logic       ready,
    output logic       empty,
    output logic       empty_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    uart_byte_t      mem [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [PW-1:0]   wr_n;
    logic [PW-1:0]   rd_n;
    logic            push_ok;
    logic            pop_ok;
    logic            full_n;

    // Next pointers; the extra MSB tells a full queue from an empty one.
    always_comb begin
        push_ok     = push & ready;
        pop_ok      = pop & ~empty;
        wr_n        = wr_q + PW'(push_ok);
        rd_n        = rd_q + PW'(pop_ok);
        full_n      = (wr_n[AW] != rd_n[AW]) && (wr_n[AW-1:0] == rd_n[AW-1:0]);
        empty_nxt_c = (wr_n == rd_n);
    end

    // Pointers and status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ready <= 1'b1;
            empty <= 1'b1;
        end else begin
            wr_q  <= wr_n;
            rd_q  <= rd_n;
            ready <= ~full_n;
            empty <= empty_nxt_c;
        end
    end

    // Storage needs no reset: contents are only visible between valid pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_q[AW-1:0]] <= push_data;
        end
    end

    assign head = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_tb_tx.sv
// UART transmitter VIP: queues bytes from a valid/ready port and sends them
// LSB-first as 8N1 frames (8E1 when UART_TB_TX_PARITY_EN is defined) with a
// runtime-programmable bit period.
// Ports: clk_i        - clock, all logic on posedge
//        rst_i        - synchronous active-high reset (aborts frame, flushes queue)
//        tx_en_i      - allow new frames to start
//        cfg_div_i    - clocks per bit minus one, latched at frame start
//        push         - byte push port (slave modport of uart_tb_tx_if)
//        tx_o         - serial line, idle high
//        busy_o       - frame in progress or queue non-empty
//        byte_done_o  - one-cycle pulse on the last clock of each stop bit
//        line_done_o  - pulses with byte_done_o when the sent byte is LF
// Build option: UART_TB_TX_PARITY_EN adds an even-parity bit before stop.
module uart_tb_tx
    import uart_tb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tx_en_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    uart_tb_tx_if.slave      push,
    output logic             tx_o,
    output logic             busy_o,
    output logic             byte_done_o,
    output logic             line_done_o
);

    localparam int unsigned BIT_CNT_W = 3;

    uart_tx_state_e         state_q;
    uart_tx_state_e         state_n;
    logic [DIV_W-1:0]       div_q;
    logic [DIV_W-1:0]       div_n;
    logic [DIV_W-1:0]       div_cnt_q;
    logic [DIV_W-1:0]       div_cnt_n;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_n;
    uart_byte_t             shift_q;
    uart_byte_t             shift_n;
    uart_byte_t             byte_q;
    uart_byte_t             byte_n;
    logic                   tx_q;
    logic                   tx_n;
    logic                   busy_q;
    logic                   busy_n;
    logic                   byte_done_q;
    logic                   byte_done_n;
    logic                   line_done_q;
    logic                   line_done_n;

    logic                   pop_c;
    logic                   load_c;
    logic                   start_ok_c;
    logic                   bit_end_c;
    uart_byte_t             fifo_head;
    logic                   fifo_empty;
    logic                   fifo_empty_nxt;

    uart_tb_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push        (push.valid),
        .push_data   (push.data),
        .pop         (pop_c),
        .head        (fifo_head),
        .ready       (push.ready),
        .empty       (fifo_empty),
        .empty_nxt_c (fifo_empty_nxt)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q       <= '0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            div_q       <= div_n;
            div_cnt_q   <= div_cnt_n;
            bit_cnt_q   <= bit_cnt_n;
            shift_q     <= shift_n;
            byte_q      <= byte_n;
            tx_q        <= tx_n;
            busy_q      <= busy_n;
            byte_done_q <= byte_done_n;
            line_done_q <= line_done_n;
        end
    end

    // Next state; tx_n is the line level for the following clock.
    always_comb begin
        state_n     = state_q;
        div_n       = div_q;
        div_cnt_n   = div_cnt_q;
        bit_cnt_n   = bit_cnt_q;
        shift_n     = shift_q;
        byte_n      = byte_q;
        tx_n        = tx_q;
        pop_c       = 1'b0;
        load_c      = 1'b0;
        start_ok_c  = tx_en_i & ~fifo_empty;
        bit_end_c   = (div_cnt_q == div_q);

        case (state_q)
            IDLE: begin
                tx_n   = 1'b1;
                load_c = start_ok_c;
            end

            START: begin
                if (bit_end_c) begin
                    state_n   = DATA;
                    div_cnt_n = '0;
                    bit_cnt_n = '0;
                    tx_n      = shift_q[0];
                end else begin
                    div_cnt_n = div_cnt_q + DIV_W'(1);
                end
            end

            DATA: begin
                if (bit_end_c) begin
                    div_cnt_n = '0;
                    if (bit_cnt_q == BIT_CNT_W'(7)) begin
`ifdef UART_TB_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = even_parity(byte_q);
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt_q + BIT_CNT_W'(1);
                        shift_n   = shift_q >> 1;
                        tx_n      = shift_q[1];
                    end
                end else begin
                    div_cnt_n = div_cnt_q + DIV_W'(1);
                end
            end

`ifdef UART_TB_TX_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    state_n   = STOP;
                    div_cnt_n = '0;
                    tx_n      = 1'b1;
                end else begin
                    div_cnt_n = div_cnt_q + DIV_W'(1);
                end
            end
`endif

            STOP: begin
                if (bit_end_c) begin
                    if (start_ok_c) begin
                        load_c = 1'b1;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    div_cnt_n = div_cnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Frame start: pop head, latch divider, drive start bit next clock.
        if (load_c) begin
            pop_c     = 1'b1;
            state_n   = START;
            tx_n      = 1'b0;
            shift_n   = fifo_head;
            byte_n    = fifo_head;
            div_n     = cfg_div_i;
            div_cnt_n = '0;
            bit_cnt_n = '0;
        end

        // Look ahead one clock so the pulse lands on the last stop-bit clock.
        byte_done_n = (state_n == STOP) && (div_cnt_n == div_q);
        line_done_n = byte_done_n && (byte_q == LF);
        busy_n      = (state_n != IDLE) || !fifo_empty_nxt;
    end

    assign tx_o        = tx_q;
    assign busy_o      = busy_q;
    assign byte_done_o = byte_done_q;
    assign line_done_o = line_done_q;

endmodule

// File: tb/tb_uart_tb_tx.sv
// Directed self-checking bench for uart_tb_tx.
// Drives bytes through the push interface and checks the serial line,
// done pulses, busy and ready clock by clock against hand-derived frames.
module tb_uart_tb_tx;

    localparam int unsigned DIV_W = 16;
`ifdef UART_TB_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             tx_en;
    logic [DIV_W-1:0] cfg_div;
    logic             tx;
    logic             busy;
    logic             byte_done;
    logic             line_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] seq [9] = '{8'h11, 8'h22, 8'h33, 8'h0A, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};

    uart_tb_tx_if push_if ();

    always #5 clk = ~clk;

    uart_tb_tx #(
        .FIFO_DEPTH (8),
        .DIV_W      (DIV_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tx_en_i     (tx_en),
        .cfg_div_i   (cfg_div),
        .push        (push_if),
        .tx_o        (tx),
        .busy_o      (busy),
        .byte_done_o (byte_done),
        .line_done_o (line_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_if.data  = b;
        push_if.valid = 1'b1;
        step();
        push_if.valid = 1'b0;
    endtask

    // Looks at the current sample first, then steps, until the start bit shows.
    task automatic wait_start(input string tag, output bit found);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check({tag, " start"}, 0, 32'(found), 32'd1);
    endtask

    // Checks one whole frame clock by clock; leaves the sample on its last clock.
    task automatic run_frame(input logic [7:0] b, input int div, input logic par, input bit b2b,
                             input int chg_at, input logic [DIV_W-1:0] chg_div, input string tag);
        bit   ok;
        int   k;
        logic e;
        logic last;
        ok = 1'b1;
        k  = 1;
        if (b2b) begin
            step();
            check({tag, " gap"}, 0, 32'(tx), 32'd0);
        end else begin
            wait_start(tag, ok);
        end
        if (ok) begin
            check({tag, " busy"}, 0, 32'(busy), 32'd1);
            for (int i = 0; i < NBITS; i++) begin
                for (int c = 0; c <= div; c++) begin
                    if (k > 1) step();
                    if (i == 0)                     e = 1'b0;
                    else if (i <= 8)                e = b[i-1];
                    else if (i == 9 && NBITS == 11) e = par;
                    else                            e = 1'b1;
                    last = (i == NBITS - 1) && (c == div);
                    check({tag, " tx"}, k, 32'(tx), 32'(e));
                    check({tag, " byte_done"}, k, 32'(byte_done), 32'(last));
                    check({tag, " line_done"}, k, 32'(line_done), 32'(last && (b == 8'h0A)));
                    if (k == chg_at) cfg_div = chg_div;
                    k++;
                end
            end
        end
    endtask

    initial begin
        bit ok;
        rst           = 1'b1;
        tx_en         = 1'b0;
        cfg_div       = 16'd3;
        push_if.data  = 8'h00;
        push_if.valid = 1'b0;

        // Reset state
        step();
        step();
        check("rst tx", 0, 32'(tx), 32'd1);
        check("rst ready", 0, 32'(push_if.ready), 32'd1);
        check("rst busy", 0, 32'(busy), 32'd0);
        check("rst byte_done", 0, 32'(byte_done), 32'd0);
        check("rst line_done", 0, 32'(line_done), 32'd0);
        rst = 1'b0;
        step();

        // 0x55 at 4 clocks per bit
        tx_en   = 1'b1;
        cfg_div = 16'd3;
        push_byte(8'h55);
        run_frame(8'h55, 3, 1'b0, 1'b0, 0, '0, "f55");
        step();
        check("f55 idle busy", 0, 32'(busy), 32'd0);
        check("f55 idle tx", 0, 32'(tx), 32'd1);

        // Line feed at 1 clock per bit
        cfg_div = 16'd0;
        push_byte(8'h0A);
        run_frame(8'h0A, 0, 1'b0, 1'b0, 0, '0, "f0a");
        step();
        check("f0a idle busy", 0, 32'(busy), 32'd0);

        // Fill queue with transmit disabled; ninth push must be dropped
        tx_en   = 1'b0;
        cfg_div = 16'd1;
        for (int i = 0; i < 9; i++) begin
            push_if.data  = seq[i];
            push_if.valid = 1'b1;
            step();
            check("fill ready", i, 32'(push_if.ready), (i < 7) ? 32'd1 : 32'd0);
        end
        push_if.valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("held tx", i, 32'(tx), 32'd1);
        end
        check("held busy", 0, 32'(busy), 32'd1);

        // Eight frames back to back
        tx_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_frame(seq[i], 1, ^seq[i], i > 0, 0, '0, $sformatf("burst%0d", i));
        end
        step();
        check("burst end busy", 0, 32'(busy), 32'd0);
        check("burst end ready", 0, 32'(push_if.ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("dropped tx", i, 32'(tx), 32'd1);
        end

`ifdef UART_TB_TX_PARITY_EN
        // Parity bits: 0x07 -> 1, 0x03 -> 0
        cfg_div = 16'd1;
        push_byte(8'h07);
        push_byte(8'h03);
        run_frame(8'h07, 1, 1'b1, 1'b0, 0, '0, "par07");
        run_frame(8'h03, 1, 1'b0, 1'b1, 0, '0, "par03");
        step();
        check("par idle busy", 0, 32'(busy), 32'd0);
`endif

        // Reset during data bit 4 of 0xA5 with a second byte still queued
        cfg_div = 16'd3;
        push_byte(8'hA5);
        push_byte(8'h3C);
        wait_start("rstmid", ok);
        for (int i = 0; i < 21; i++) step();
        check("rstmid bit4 tx", 0, 32'(tx), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid tx", 0, 32'(tx), 32'd1);
        check("rstmid busy", 0, 32'(busy), 32'd0);
        check("rstmid ready", 0, 32'(push_if.ready), 32'd1);
        check("rstmid byte_done", 0, 32'(byte_done), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("flushed tx", i, 32'(tx), 32'd1);
            check("flushed byte_done", i, 32'(byte_done), 32'd0);
        end
        check("flushed busy", 0, 32'(busy), 32'd0);

        // Divider change mid-frame applies to the next frame only
        cfg_div = 16'd3;
        push_byte(8'h96);
        push_byte(8'h69);
        run_frame(8'h96, 3, 1'b0, 1'b0, 10, 16'd1, "dchg0");
        run_frame(8'h69, 1, 1'b0, 1'b1, 0, '0, "dchg1");
        step();
        check("dchg idle busy", 0, 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
